sobel_frame_sequencer: RTL

//  Parametrised frame sequencer for the Sobel edge pipeline; successor to the fixed 3x3 controller.

---
 rtl/sobel_frame_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_frame_sequencer.sv
// Sobel frame sequencer: walks a 3x3 window over a WxH frame in raster order, one request pulse at a time.
// Latency 1 cycle from an accepted done to the next request; waits indefinitely on each done (SOBEL_BORDER_ZERO_EN adds zero border writes).
module sobel_frame_sequencer #(
    parameter int CW    = 10,
    parameter int MAX_W = 640,
    parameter int MAX_H = 480
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] cfg_width,
    input  logic [CW-1:0] cfg_height,
    input  logic          read_done,
    input  logic          shift_done,
    input  logic          calculation_done,
    input  logic          write_done,
    output logic          start_read,
    output logic [CW-1:0] rd_row,
    output logic [CW-1:0] rd_col,
    output logic          start_shift,
    output logic          start_calculation,
    output logic          start_write,
    output logic [CW-1:0] wr_row,
    output logic [CW-1:0] wr_col,
    output logic          wr_zero,
    output logic          busy,
    output logic          image_done,
    output logic          param_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_PRIME, S_READ_COL, S_CALC, S_WRITE, S_SHIFT, S_DONE,
        S_BROW, S_BLEFT, S_BRIGHT
    } state_t;

    localparam logic [CW-1:0] L_MAX_W = CW'(MAX_W);
    localparam logic [CW-1:0] L_MAX_H = CW'(MAX_H);
    localparam logic [CW-1:0] L_MIN   = CW'(3);
    localparam logic [CW-1:0] L_ONE   = CW'(1);
    localparam logic [CW-1:0] L_TWO   = CW'(2);

    state_t        r_state;
    logic [CW-1:0] r_w;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [3:0]    r_idx;
    logic          r_start_read;
    logic          r_start_shift;
    logic          r_start_calc;
    logic          r_start_write;
    logic          r_image_done;
    logic          r_param_err;
    logic [CW-1:0] r_rd_row;
    logic [CW-1:0] r_rd_col;
    logic [CW-1:0] r_wr_row;
    logic [CW-1:0] r_wr_col;
`ifdef SOBEL_BORDER_ZERO_EN
    logic          r_wr_zero;
`endif

    // Priming order is column-major: index k reads row offset k%3, column offset k/3.
    function automatic logic [1:0] f_div3(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: f_div3 = 2'd0;
            4'd3, 4'd4, 4'd5: f_div3 = 2'd1;
            default:          f_div3 = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] f_mod3(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: f_mod3 = 2'd0;
            4'd1, 4'd4, 4'd7: f_mod3 = 2'd1;
            default:          f_mod3 = 2'd2;
        endcase
    endfunction

    logic [3:0]    w_nidx;
    logic [CW-1:0] w_prime_row;
    logic [CW-1:0] w_prime_col;
    logic [CW-1:0] w_col_row;
    logic          w_rd_acc;
    logic          w_sh_acc;
    logic          w_ca_acc;
    logic          w_wr_acc;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_cfg_bad;

    assign w_nidx      = r_idx + 4'd1;
    assign w_prime_row = r_row - L_ONE + CW'(f_mod3(w_nidx));
    assign w_prime_col = r_col - L_ONE + CW'(f_div3(w_nidx));
    assign w_col_row   = r_row - L_ONE + CW'(w_nidx);

    // A done only counts once the pulse cycle has passed.
    assign w_rd_acc = read_done        && !r_start_read;
    assign w_sh_acc = shift_done       && !r_start_shift;
    assign w_ca_acc = calculation_done && !r_start_calc;
    assign w_wr_acc = write_done       && !r_start_write;

    assign w_last_col = (r_col >= r_w - L_TWO);
    assign w_last_row = (r_row >= r_h - L_TWO);
    assign w_cfg_bad  = (cfg_width < L_MIN) || (cfg_height < L_MIN) ||
                        (cfg_width > L_MAX_W) || (cfg_height > L_MAX_H);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_w           <= '0;
            r_h           <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_idx         <= '0;
            r_start_read  <= 1'b0;
            r_start_shift <= 1'b0;
            r_start_calc  <= 1'b0;
            r_start_write <= 1'b0;
            r_image_done  <= 1'b0;
            r_param_err   <= 1'b0;
            r_rd_row      <= '0;
            r_rd_col      <= '0;
            r_wr_row      <= '0;
            r_wr_col      <= '0;
`ifdef SOBEL_BORDER_ZERO_EN
            r_wr_zero     <= 1'b0;
`endif
        end else begin
            r_start_read  <= 1'b0;
            r_start_shift <= 1'b0;
            r_start_calc  <= 1'b0;
            r_start_write <= 1'b0;
            r_image_done  <= 1'b0;
            if (abort) begin
                r_state  <= S_IDLE;
                r_rd_row <= '0;
                r_rd_col <= '0;
                r_wr_row <= '0;
                r_wr_col <= '0;
`ifdef SOBEL_BORDER_ZERO_EN
                r_wr_zero <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state     <= S_LOAD;
                            r_param_err <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        r_w <= cfg_width;
                        r_h <= cfg_height;
                        if (w_cfg_bad) begin
                            r_param_err <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
`ifdef SOBEL_BORDER_ZERO_EN
                            r_row         <= '0;
                            r_col         <= '0;
                            r_state       <= S_BROW;
                            r_start_write <= 1'b1;
                            r_wr_row      <= '0;
                            r_wr_col      <= '0;
                            r_wr_zero     <= 1'b1;
`else
                            r_row        <= L_ONE;
                            r_col        <= L_ONE;
                            r_idx        <= '0;
                            r_state      <= S_PRIME;
                            r_start_read <= 1'b1;
                            r_rd_row     <= '0;
                            r_rd_col     <= '0;
`endif
                        end
                    end
                    S_PRIME: begin
                        if (w_rd_acc) begin
                            if (r_idx == 4'd8) begin
                                r_state      <= S_CALC;
                                r_start_calc <= 1'b1;
                            end else begin
                                r_idx        <= w_nidx;
                                r_start_read <= 1'b1;
                                r_rd_row     <= w_prime_row;
                                r_rd_col     <= w_prime_col;
                            end
                        end
                    end
                    S_READ_COL: begin
                        if (w_rd_acc) begin
                            if (r_idx == 4'd2) begin
                                r_state      <= S_CALC;
                                r_start_calc <= 1'b1;
                            end else begin
                                r_idx        <= w_nidx;
                                r_start_read <= 1'b1;
                                r_rd_row     <= w_col_row;
                                r_rd_col     <= r_col + L_ONE;
                            end
                        end
                    end
                    S_CALC: begin
                        if (w_ca_acc) begin
                            r_state       <= S_WRITE;
                            r_start_write <= 1'b1;
                            r_wr_row      <= r_row;
                            r_wr_col      <= r_col;
`ifdef SOBEL_BORDER_ZERO_EN
                            r_wr_zero     <= 1'b0;
`endif
                        end
                    end
                    S_WRITE: begin
                        if (w_wr_acc) begin
                            if (!w_last_col) begin
                                r_state       <= S_SHIFT;
                                r_start_shift <= 1'b1;
                            end else begin
`ifdef SOBEL_BORDER_ZERO_EN
                                r_state       <= S_BRIGHT;
                                r_start_write <= 1'b1;
                                r_wr_row      <= r_row;
                                r_wr_col      <= r_w - L_ONE;
                                r_wr_zero     <= 1'b1;
`else
                                if (!w_last_row) begin
                                    r_row        <= r_row + L_ONE;
                                    r_col        <= L_ONE;
                                    r_idx        <= '0;
                                    r_state      <= S_PRIME;
                                    r_start_read <= 1'b1;
                                    r_rd_row     <= r_row;
                                    r_rd_col     <= '0;
                                end else begin
                                    r_state      <= S_DONE;
                                    r_image_done <= 1'b1;
                                end
`endif
                            end
                        end
                    end
                    S_SHIFT: begin
                        if (w_sh_acc) begin
                            r_col        <= r_col + L_ONE;
                            r_idx        <= '0;
                            r_state      <= S_READ_COL;
                            r_start_read <= 1'b1;
                            r_rd_row     <= r_row - L_ONE;
                            r_rd_col     <= r_col + L_TWO;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
`ifdef SOBEL_BORDER_ZERO_EN
                    S_BROW: begin
                        if (w_wr_acc) begin
                            if (r_wr_col != r_w - L_ONE) begin
                                r_start_write <= 1'b1;
                                r_wr_col      <= r_wr_col + L_ONE;
                            end else if (r_wr_row == '0) begin
                                r_row         <= L_ONE;
                                r_state       <= S_BLEFT;
                                r_start_write <= 1'b1;
                                r_wr_row      <= L_ONE;
                                r_wr_col      <= '0;
                            end else begin
                                r_state      <= S_DONE;
                                r_image_done <= 1'b1;
                            end
                        end
                    end
                    S_BLEFT: begin
                        if (w_wr_acc) begin
                            r_col        <= L_ONE;
                            r_idx        <= '0;
                            r_state      <= S_PRIME;
                            r_start_read <= 1'b1;
                            r_rd_row     <= r_row - L_ONE;
                            r_rd_col     <= '0;
                        end
                    end
                    S_BRIGHT: begin
                        if (w_wr_acc) begin
                            r_start_write <= 1'b1;
                            r_wr_col      <= '0;
                            if (!w_last_row) begin
                                r_row    <= r_row + L_ONE;
                                r_state  <= S_BLEFT;
                                r_wr_row <= r_row + L_ONE;
                            end else begin
                                r_state  <= S_BROW;
                                r_wr_row <= r_h - L_ONE;
                            end
                        end
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign start_read        = r_start_read;
    assign rd_row            = r_rd_row;
    assign rd_col            = r_rd_col;
    assign start_shift       = r_start_shift;
    assign start_calculation = r_start_calc;
    assign start_write       = r_start_write;
    assign wr_row            = r_wr_row;
    assign wr_col            = r_wr_col;
    assign busy              = (r_state != S_IDLE);
    assign image_done        = r_image_done;
    assign param_err         = r_param_err;
`ifdef SOBEL_BORDER_ZERO_EN
    assign wr_zero           = r_wr_zero;
`else
    assign wr_zero           = 1'b0;
`endif

endmodule
